// File: rtl/banco_registros_pkg.sv
// Shared constants and the address-width helper for the register bank.
package banco_registros_pkg;

    localparam int ANCHO_DEF = 32;
    localparam int NREG_DEF  = 32;

    // Smallest address width covering n entries (minimum 1 bit).
    function automatic int dir_ancho(input int n);
        dir_ancho = 1;
        for (int unsigned i = 1; i < 7; i++) begin
            if ((32'd1 << i) < n) dir_ancho = int'(i) + 1;
        end
    endfunction

endpackage

// File: rtl/marcador_pendientes.sv
// Pending-load scoreboard: one bit per register, set by a reservation and
// cleared by the write that retires it.
module marcador_pendientes
    import banco_registros_pkg::*;
#(
    parameter int NREG      = NREG_DEF,
    parameter int NLEC      = 2,
    parameter int BYPASS    = 1,
    parameter int CERO_FIJO = 1,
    parameter int DIR_W     = dir_ancho(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NLEC*DIR_W-1:0] dirlec,
    output logic [NLEC-1:0]       listolec,
    input  logic                  enesc,
    input  logic [DIR_W-1:0]      diresc,
    input  logic                  enres,
    input  logic [DIR_W-1:0]      dirres,
    output logic [NREG-1:0]       pendientes
);

    logic [NREG-1:0]  pend_q;
    logic [NREG-1:0]  pend_d;
    logic [DIR_W-1:0] dir_k;

    // Reservation is applied after the clear so it wins on the same address.
    always_comb begin
        pend_d = pend_q;
        if (enesc) pend_d[diresc] = 1'b0;
        if (enres) pend_d[dirres] = 1'b1;
        if (CERO_FIJO != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    always_comb begin
        listolec = '0;
        dir_k    = '0;
        for (int unsigned k = 0; k < NLEC; k++) begin
            dir_k       = dirlec[k*DIR_W +: DIR_W];
            listolec[k] = ~pend_q[dir_k];
            if ((BYPASS != 0) && enesc && (diresc == dir_k) && !(enres && (dirres == dir_k)))
                listolec[k] = 1'b1;
        end
    end

    assign pendientes = pend_q;

endmodule

// File: rtl/banco_registros.sv
// Multi-port register file with optional write-through bypass, hardwired
// zero register and a pending-load scoreboard.
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int NLEC      = 2,
    parameter int BYPASS    = 1,
    parameter int CERO_FIJO = 1,
    localparam int DIR_W    = dir_ancho(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NLEC*DIR_W-1:0] dirlec,
    output logic [NLEC*ANCHO-1:0] datolec,
    output logic [NLEC-1:0]       listolec,
    input  logic                  enesc,
    input  logic [DIR_W-1:0]      diresc,
    input  logic [ANCHO-1:0]      datoesc,
    input  logic                  enres,
    input  logic [DIR_W-1:0]      dirres,
    output logic [NREG-1:0]       pendientes
);

    logic [ANCHO-1:0] mem_q [NREG];
    logic             escribe;
    logic [DIR_W-1:0] dir_k;
    logic [ANCHO-1:0] dato_k;

    assign escribe = enesc && !((CERO_FIJO != 0) && (diresc == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (escribe) begin
            mem_q[diresc] <= datoesc;
        end
    end

    // Bypass is masked during reset so reads show the cleared array.
    always_comb begin
        datolec = '0;
        dir_k   = '0;
        dato_k  = '0;
        for (int unsigned k = 0; k < NLEC; k++) begin
            dir_k  = dirlec[k*DIR_W +: DIR_W];
            dato_k = mem_q[dir_k];
            if ((BYPASS != 0) && rst_n && escribe && (diresc == dir_k)) dato_k = datoesc;
            if ((CERO_FIJO != 0) && (dir_k == '0)) dato_k = '0;
            datolec[k*ANCHO +: ANCHO] = dato_k;
        end
    end

    marcador_pendientes #(
        .NREG      (NREG),
        .NLEC      (NLEC),
        .BYPASS    (BYPASS),
        .CERO_FIJO (CERO_FIJO),
        .DIR_W     (DIR_W)
    ) u_marcador (
        .clk        (clk),
        .rst_n      (rst_n),
        .dirlec     (dirlec),
        .listolec   (listolec),
        .enesc      (enesc),
        .diresc     (diresc),
        .enres      (enres),
        .dirres     (dirres),
        .pendientes (pendientes)
    );

endmodule

// File: tb/tb_banco_registros.sv
// Scoreboard bench: instance A is the default bypass build, instance B is a
// 4-port 16x16 build without bypass.
module tb_banco_registros;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [9:0]  a_dirlec;
    logic [63:0] a_datolec;
    logic [1:0]  a_listo;
    logic        a_enesc, a_enres;
    logic [4:0]  a_diresc, a_dirres;
    logic [31:0] a_datoesc, a_pend;

    logic [15:0] b_dirlec;
    logic [63:0] b_datolec;
    logic [3:0]  b_listo;
    logic        b_enesc, b_enres;
    logic [3:0]  b_diresc, b_dirres;
    logic [15:0] b_datoesc, b_pend;

    banco_registros #(.ANCHO(32), .NREG(32), .NLEC(2), .BYPASS(1), .CERO_FIJO(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .dirlec(a_dirlec), .datolec(a_datolec), .listolec(a_listo),
        .enesc(a_enesc), .diresc(a_diresc), .datoesc(a_datoesc), .enres(a_enres),
        .dirres(a_dirres), .pendientes(a_pend));

    banco_registros #(.ANCHO(16), .NREG(16), .NLEC(4), .BYPASS(0), .CERO_FIJO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .dirlec(b_dirlec), .datolec(b_datolec), .listolec(b_listo),
        .enesc(b_enesc), .diresc(b_diresc), .datoesc(b_datoesc), .enres(b_enres),
        .dirres(b_dirres), .pendientes(b_pend));

    typedef struct {
        string       nom;
        int          sel;
        int          idx;
        logic [63:0] esp;
    } item_t;

    item_t       sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    item_t       mon_it;
    logic [63:0] mon_act;

    task automatic push(input string nom, input int sel, input int idx, input logic [63:0] esp);
        item_t it;
        it.nom = nom; it.sel = sel; it.idx = idx; it.esp = esp;
        sb.push_back(it);
    endtask

    task automatic ea(input string n, input int k, input logic [63:0] v); push(n, 0, k, v); endtask
    task automatic la(input string n, input int k, input logic [63:0] v); push(n, 1, k, v); endtask
    task automatic pa(input string n, input logic [63:0] v);              push(n, 2, 0, v); endtask
    task automatic eb(input string n, input int k, input logic [63:0] v); push(n, 3, k, v); endtask
    task automatic lb(input string n, input int k, input logic [63:0] v); push(n, 4, k, v); endtask
    task automatic pb(input string n, input logic [63:0] v);              push(n, 5, 0, v); endtask

    function automatic logic [63:0] actual(input int sel, input int idx);
        case (sel)
            0:       return {32'd0, a_datolec[idx*32 +: 32]};
            1:       return {63'd0, a_listo[idx]};
            2:       return {32'd0, a_pend};
            3:       return {48'd0, b_datolec[idx*16 +: 16]};
            4:       return {63'd0, b_listo[idx]};
            5:       return {48'd0, b_pend};
            default: return '0;
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at negedge.
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            mon_it  = sb.pop_front();
            mon_act = actual(mon_it.sel, mon_it.idx);
            n_tests++;
            if (mon_act !== mon_it.esp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h (t=%0t)", mon_it.nom, mon_act, mon_it.esp, $time);
            end
        end
    end

    task automatic esperar();
        @(posedge clk);
        #1;
    endtask

    int addr;

    initial begin
        rst_n = 1'b0;
        a_dirlec = '0; a_enesc = 1'b0; a_diresc = '0; a_datoesc = '0; a_enres = 1'b0; a_dirres = '0;
        b_dirlec = '0; b_enesc = 1'b0; b_diresc = '0; b_datoesc = '0; b_enres = 1'b0; b_dirres = '0;
        repeat (2) @(posedge clk);
        #1;
        pa("rst_pend_a", 0); la("rst_listo_a0", 0, 1); la("rst_listo_a1", 1, 1);
        pb("rst_pend_b", 0);
        for (int k = 0; k < 4; k++) lb("rst_listo_b", k, 1);
        esperar();
        rst_n = 1'b1;

        // Post-reset sweep of every address on both ports.
        for (int i = 0; i < 32; i++) begin
            a_dirlec = {5'(31 - i), 5'(i)};
            ea("sweep_d0", 0, 0); ea("sweep_d1", 1, 0);
            la("sweep_l0", 0, 1); la("sweep_l1", 1, 1);
            pa("sweep_pend", 0);
            esperar();
        end

        // Write-through vs registered read of r5.
        a_enesc = 1'b1; a_diresc = 5'd5; a_datoesc = 32'hDEADBEEF; a_dirlec = {5'd5, 5'd5};
        b_enesc = 1'b1; b_diresc = 4'd5; b_datoesc = 16'hBEEF;
        b_dirlec = {4'd0, 4'd0, 4'd5, 4'd5};
        ea("byp_r5_p0", 0, 32'hDEADBEEF); ea("byp_r5_p1", 1, 32'hDEADBEEF);
        eb("nobyp_r5_old", 0, 0);
        esperar();
        a_enesc = 1'b0; b_enesc = 1'b0;
        ea("r5_after", 0, 32'hDEADBEEF); eb("nobyp_r5_new", 0, 16'hBEEF); eb("nobyp_r5_p1", 1, 16'hBEEF);
        esperar();

        // Register 0 ignores writes and reservations.
        a_enesc = 1'b1; a_diresc = '0; a_datoesc = 32'h12345678; a_enres = 1'b1; a_dirres = '0; a_dirlec = '0;
        b_enesc = 1'b1; b_diresc = '0; b_datoesc = 16'h1234;     b_enres = 1'b1; b_dirres = '0; b_dirlec = '0;
        ea("r0_byp_p0", 0, 0); ea("r0_byp_p1", 1, 0); eb("r0_b", 0, 0);
        esperar();
        a_enesc = 1'b0; a_enres = 1'b0; b_enesc = 1'b0; b_enres = 1'b0;
        ea("r0_after_p0", 0, 0); ea("r0_after_p1", 1, 0);
        pa("r0_not_pend", 0); pb("r0_not_pend_b", 0); eb("r0_after_b", 0, 0);
        esperar();

        // Reserve r7, three idle cycles, then retire it with a write.
        a_enres = 1'b1; a_dirres = 5'd7; a_dirlec = {5'd7, 5'd7};
        b_enres = 1'b1; b_dirres = 4'd7; b_dirlec = {4'd7, 4'd7, 4'd7, 4'd7};
        la("r7_res_cycle", 0, 1); lb("r7_res_cycle_b", 0, 1);
        esperar();
        a_enres = 1'b0; b_enres = 1'b0;
        for (int i = 0; i < 3; i++) begin
            la("r7_wait_p0", 0, 0); la("r7_wait_p1", 1, 0); pa("r7_pend", 32'h80);
            lb("r7_wait_b", 0, 0); lb("r7_wait_b3", 3, 0); pb("r7_pend_b", 16'h80);
            esperar();
        end
        a_enesc = 1'b1; a_diresc = 5'd7; a_datoesc = 32'h55;
        b_enesc = 1'b1; b_diresc = 4'd7; b_datoesc = 16'h55;
        la("r7_wr_fwd", 0, 1); ea("r7_wr_dato", 0, 32'h55); pa("r7_wr_pend", 32'h80);
        lb("r7_wr_nofwd", 0, 0); eb("r7_wr_old_b", 0, 0); pb("r7_wr_pend_b", 16'h80);
        esperar();
        a_enesc = 1'b0; b_enesc = 1'b0;
        la("r7_after", 0, 1); pa("r7_after_pend", 0); ea("r7_after_dato", 0, 32'h55);
        lb("r7_after_b", 0, 1); pb("r7_after_pend_b", 0); eb("r7_after_dato_b", 0, 16'h55);
        esperar();

        // Same-cycle reservation and write of r9: reservation wins.
        a_enres = 1'b1; a_dirres = 5'd9; a_enesc = 1'b1; a_diresc = 5'd9; a_datoesc = 32'h99;
        a_dirlec = {5'd9, 5'd9};
        la("r9_same_l0", 0, 1); la("r9_same_l1", 1, 1); ea("r9_same_d", 0, 32'h99);
        esperar();
        // Reserve r10 while writing r9: both apply on the same edge.
        a_dirres = 5'd10; a_datoesc = 32'h77;
        pa("r9_res_win", 32'h200); la("r9_fwd_listo", 0, 1); ea("r9_fwd_d", 0, 32'h77);
        esperar();
        a_enres = 1'b0; a_enesc = 1'b0; a_dirlec = {5'd10, 5'd9};
        pa("diff_addr_pend", 32'h400); la("r9_free", 0, 1); la("r10_busy", 1, 0);
        ea("r9_val", 0, 32'h77);
        esperar();

        // Reset asserted mid-cycle while a write to r3 is presented.
        a_enesc = 1'b1; a_diresc = 5'd3; a_datoesc = 32'hA5; a_dirlec = {5'd3, 5'd3};
        esperar();
        a_enesc = 1'b0;
        ea("r3_a5", 0, 32'hA5);
        esperar();
        a_enesc = 1'b1; a_datoesc = 32'hFF;
        #2 rst_n = 1'b0;
        #1;
        ea("r3_rst_now", 0, 0); pa("rst_mid_pend", 0); la("rst_mid_l1", 1, 1);
        esperar();
        ea("r3_rst_hold", 0, 0);
        esperar();
        a_enesc = 1'b0;
        rst_n = 1'b1;
        a_dirlec = {5'd5, 5'd3};
        ea("r3_post", 0, 0); ea("r5_post", 1, 0);
        esperar();

        // Four-port read of r1..r15 = i*0x111 on instance B.
        for (int i = 1; i < 16; i++) begin
            b_enesc = 1'b1; b_diresc = 4'(i); b_datoesc = 16'(i * 'h111);
            esperar();
        end
        b_enesc = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) b_dirlec[k*4 +: 4] = 4'((i + k) % 16);
            for (int k = 0; k < 4; k++) begin
                addr = (i + k) % 16;
                eb("b4_read", k, 64'(addr * 'h111));
                lb("b4_listo", k, 1);
            end
            esperar();
        end
        pb("b4_pend", 0);
        esperar();

        repeat (4) if (sb.size() != 0) esperar();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d unchecked expectations, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
